// File: rtl/cycle_sequencer_pkg.sv
// seq_pkg: sequencer state and opcode-class types plus per-class instruction lengths
package seq_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} seq_state_t;
    typedef enum logic [3:0] {MOV8, SETAB, ALU, LDST, MOV16, HALT, INCXY, GOTO, ILLEGAL} op_class_t;
    localparam int LEN_SHORT = 8;
    localparam int LEN_MOV16 = 10;
    localparam int LEN_LDST  = 12;
    localparam int LEN_INCXY = 14;
    localparam int LEN_GOTO  = 24;
    function automatic logic [7:0] class_len(input op_class_t c);
        return (c == LDST) ? 8'(LEN_LDST) :
               (c == MOV16 || c == HALT) ? 8'(LEN_MOV16) :
               (c == INCXY) ? 8'(LEN_INCXY) :
               (c == GOTO) ? 8'(LEN_GOTO) : 8'(LEN_SHORT);
    endfunction
endpackage

// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if: control/step bundle between sequencer and control decode; SEQ_ILLEGAL_TRAP_EN adds illegal_op
interface cycle_sequencer_if #(parameter int MAX_STEPS = 24);
    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    logic              run;
    logic              hold;
    logic              halt_clear;
    logic [7:0]        instruction_reg;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] cycle_len;
    logic              fetch_phase;
    logic              exec_phase;
    logic              ld_inst_strobe;
    logic              instr_done;
    logic              halted;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic              illegal_op;
    modport master (output run, hold, halt_clear, instruction_reg,
                    input step, cycle_len, fetch_phase, exec_phase, ld_inst_strobe, instr_done, halted, illegal_op);
    modport slave  (input run, hold, halt_clear, instruction_reg,
                    output step, cycle_len, fetch_phase, exec_phase, ld_inst_strobe, instr_done, halted, illegal_op);
`else
    modport master (output run, hold, halt_clear, instruction_reg,
                    input step, cycle_len, fetch_phase, exec_phase, ld_inst_strobe, instr_done, halted);
    modport slave  (input run, hold, halt_clear, instruction_reg,
                    output step, cycle_len, fetch_phase, exec_phase, ld_inst_strobe, instr_done, halted);
`endif
endinterface

// File: rtl/cycle_sequencer_decode.sv
// cycle_sequencer_decode: opcode -> {class, total step length}; HALT is matched before the MOV16 group it sits in
module cycle_sequencer_decode
    import seq_pkg::*;
(
    input  logic [7:0] opcode,
    output op_class_t  op_class,
    output logic [7:0] length
);
    assign op_class = (opcode == 8'hAE) ? HALT :
                      (opcode[7:6] == 2'b00) ? MOV8 :
                      (opcode[7:6] == 2'b01) ? SETAB :
                      (opcode[7:6] == 2'b11) ? GOTO :
                      (opcode[5:4] == 2'b00) ? ALU :
                      (opcode[5:4] == 2'b01 && !opcode[2]) ? LDST :
                      (opcode[5:4] == 2'b10) ? MOV16 :
                      (opcode == 8'hB0) ? INCXY : ILLEGAL;
    assign length = class_len(op_class);
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: fetch/execute step sequencer with hold, run/idle and halt latch; SEQ_ILLEGAL_TRAP_EN traps illegal opcodes
module cycle_sequencer
    import seq_pkg::*;
#(
    parameter int MAX_STEPS   = 24,
    parameter int FETCH_STEPS = 4
) (
    input logic             clock,
    input logic             initialize_n,
    cycle_sequencer_if.slave bus
);
    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] FETCH_END = STEP_W'(FETCH_STEPS);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] ONE       = STEP_W'(1);

    if (FETCH_STEPS >= 8) begin : g_bad_fetch
        $error("FETCH_STEPS must be below 8");
    end

    seq_state_t        state_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] len_q;
    logic [STEP_W-1:0] len_d;
    logic              halt_op_q;
    logic              trap_d;
    logic              last_step;
    op_class_t         dec_class;
    logic [7:0]        dec_len;

    cycle_sequencer_decode u_decode (
        .opcode   (bus.instruction_reg),
        .op_class (dec_class),
        .length   (dec_len)
    );

    assign len_d     = (32'(dec_len) > MAX_STEPS) ? STEP_MAX : STEP_W'(dec_len);
    assign last_step = step_q >= len_q;

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign trap_d = dec_class == ILLEGAL;
    // remember why we halted until the operator clears HALTED
    always_ff @(posedge clock or negedge initialize_n) begin
        if (!initialize_n) illegal_q <= 1'b0;
        else if (!bus.hold && state_q == FETCH && step_q == FETCH_END && trap_d) illegal_q <= 1'b1;
        else if (!bus.hold && state_q == HALTED && bus.halt_clear) illegal_q <= 1'b0;
    end
    assign bus.illegal_op = illegal_q;
`else
    assign trap_d = 1'b0;
`endif

    // state/step sequencing; hold freezes everything, length is latched as fetch ends
    always_ff @(posedge clock or negedge initialize_n) begin
        if (!initialize_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            len_q     <= '0;
            halt_op_q <= 1'b0;
        end else if (!bus.hold) begin
            case (state_q)
                IDLE: if (bus.run) begin
                    state_q <= FETCH;
                    step_q  <= ONE;
                end
                FETCH: if (step_q == FETCH_END) begin
                    len_q     <= len_d;
                    halt_op_q <= dec_class == HALT;
                    state_q   <= trap_d ? HALTED : EXEC;
                    step_q    <= trap_d ? '0 : step_q + ONE;
                end else begin
                    step_q <= step_q + ONE;
                end
                EXEC: if (last_step) begin
                    state_q <= halt_op_q ? HALTED : bus.run ? FETCH : IDLE;
                    step_q  <= (!halt_op_q && bus.run) ? ONE : '0;
                end else begin
                    step_q <= step_q + ONE;
                end
                HALTED: if (bus.halt_clear) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.step           = step_q;
    assign bus.cycle_len      = len_q;
    assign bus.fetch_phase    = state_q == FETCH;
    assign bus.exec_phase     = state_q == EXEC;
    assign bus.halted         = state_q == HALTED;
    assign bus.ld_inst_strobe = state_q == FETCH && step_q == FETCH_END && !bus.hold;
    assign bus.instr_done     = state_q == EXEC && last_step && !bus.hold;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed + randomized scoreboard bench for cycle_sequencer
module tb_cycle_sequencer;
    localparam int FS = 4;
    localparam int NRAND = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_q[$];

    cycle_sequencer_if #(.MAX_STEPS(24)) bus ();

    cycle_sequencer #(.MAX_STEPS(24), .FETCH_STEPS(FS)) dut (
        .clock        (clk),
        .initialize_n (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int exp_len(input logic [7:0] op);
        if (op == 8'hAE) return 10;
        if (op[7:6] == 2'b11) return 24;
        if (op[7:6] != 2'b10) return 8;
        if (op[7:4] == 4'b1000) return 8;
        if (op[7:4] == 4'b1001) return (op[3:2] == 2'b00 || op[3:2] == 2'b10) ? 12 : 8;
        if (op[7:4] == 4'b1010) return 10;
        return (op == 8'hB0) ? 14 : 8;
    endfunction

    function automatic bit is_illegal(input logic [7:0] op);
        return (op[7:4] == 4'b1001 && op[2]) || (op[7:4] == 4'b1011 && op != 8'hB0);
    endfunction

    function automatic logic [7:0] rand_op();
        logic [7:0] op;
        bit skip;
        do begin
            op = 8'($urandom);
            skip = op == 8'hAE;
`ifdef SEQ_ILLEGAL_TRAP_EN
            skip = skip || is_illegal(op);
`endif
        end while (skip);
        return op;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int s);
        for (int i = 0; i < 200; i++) begin
            if (int'(bus.step) == s) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL wait_step: step %0d not reached, got %0d", s, bus.step);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (bus.instr_done) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL wait_done: instr_done got 0 want 1 within 200 cycles");
    endtask

    // monitor: counts unheld active cycles and loads, checks each completion against the scoreboard
    initial begin
        int act = 0;
        int ld = 0;
        int e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 0;
                ld = 0;
            end else begin
                if ((bus.fetch_phase || bus.exec_phase) && !bus.hold) act++;
                if (bus.ld_inst_strobe) begin
                    ld++;
                    chk("ld_step", int'(bus.step), FS);
                end
                if (bus.instr_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected_done: got done at step %0d want none", bus.step);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_len", int'(bus.cycle_len), e);
                        chk("done_step", int'(bus.step), e);
                        chk("done_active_cycles", act, e);
                        chk("done_loads", ld, 1);
                    end
                    act = 0;
                    ld = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int issued;
        bit fin;
        logic [7:0] op;
        bus.run = 1'b0;
        bus.hold = 1'b0;
        bus.halt_clear = 1'b0;
        bus.instruction_reg = 8'h00;
        repeat (2) tick();
        chk("rst_step", int'(bus.step), 0);
        chk("rst_len", int'(bus.cycle_len), 0);
        chk("rst_fetch", int'(bus.fetch_phase), 0);
        chk("rst_exec", int'(bus.exec_phase), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_done", int'(bus.instr_done), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_step", int'(bus.step), 0);

        // ALU op, step by step
        bus.instruction_reg = 8'h80;
        exp_q.push_back(exp_len(8'h80));
        bus.run = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk("alu_step", int'(bus.step), i);
            chk("alu_fetch", int'(bus.fetch_phase), int'(i <= FS));
            chk("alu_exec", int'(bus.exec_phase), int'(i > FS));
            chk("alu_ld", int'(bus.ld_inst_strobe), int'(i == FS));
            chk("alu_done", int'(bus.instr_done), int'(i == 8));
            if (i > FS) chk("alu_len", int'(bus.cycle_len), 8);
            tick();
        end
        chk("alu_next_step", int'(bus.step), 1);
        chk("alu_next_fetch", int'(bus.fetch_phase), 1);
        exp_q.push_back(8);
        bus.run = 1'b0;
        wait_done();
        tick();
        chk("alu_idle_step", int'(bus.step), 0);
        chk("alu_idle_fetch", int'(bus.fetch_phase), 0);

        // JUMP with hold at step 10
        bus.instruction_reg = 8'hE6;
        exp_q.push_back(exp_len(8'hE6));
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        wait_step(10);
        d0 = done_cnt;
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_step", int'(bus.step), 10);
            chk("hold_ld", int'(bus.ld_inst_strobe), 0);
        end
        bus.hold = 1'b0;
        wait_done();
        chk("jump_last_step", int'(bus.step), 24);
        tick();
        chk("jump_idle_step", int'(bus.step), 0);
        chk("jump_done_once", done_cnt - d0, 1);

        // HALT
        bus.instruction_reg = 8'hAE;
        exp_q.push_back(exp_len(8'hAE));
        bus.run = 1'b1;
        tick();
        wait_done();
        chk("halt_last_step", int'(bus.step), 10);
        tick();
        chk("halt_halted", int'(bus.halted), 1);
        chk("halt_step", int'(bus.step), 0);
        repeat (2) tick();
        chk("halt_ignores_run", int'(bus.halted), 1);
        chk("halt_no_fetch", int'(bus.fetch_phase), 0);
        bus.hold = 1'b1;
        bus.halt_clear = 1'b1;
        tick();
        chk("halt_hold_wins", int'(bus.halted), 1);
        bus.hold = 1'b0;
        bus.run = 1'b0;
        tick();
        bus.halt_clear = 1'b0;
        chk("halt_cleared", int'(bus.halted), 0);
        chk("halt_clear_step", int'(bus.step), 0);
        tick();
        chk("halt_clear_idle", int'(bus.fetch_phase), 0);

        // STORE with run dropped at step 6
        bus.instruction_reg = 8'h98;
        exp_q.push_back(exp_len(8'h98));
        bus.run = 1'b1;
        tick();
        wait_step(6);
        bus.run = 1'b0;
        wait_done();
        chk("store_len", int'(bus.cycle_len), 12);
        tick();
        chk("store_idle_step", int'(bus.step), 0);
        chk("store_idle_exec", int'(bus.exec_phase), 0);

        // GOTO aborted by reset at step 17 (no scoreboard entry: no completion allowed)
        bus.instruction_reg = 8'hC0;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        wait_step(17);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_step", int'(bus.step), 0);
        chk("arst_exec", int'(bus.exec_phase), 0);
        chk("arst_len", int'(bus.cycle_len), 0);
        chk("arst_done", int'(bus.instr_done), 0);
        #5;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_idle_step", int'(bus.step), 0);
        chk("arst_no_done", done_cnt - d0, 0);

        // illegal opcode
        bus.instruction_reg = 8'hBF;
`ifdef SEQ_ILLEGAL_TRAP_EN
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        wait_step(FS);
        chk("trap_fetch", int'(bus.fetch_phase), 1);
        tick();
        chk("trap_halted", int'(bus.halted), 1);
        chk("trap_flag", int'(bus.illegal_op), 1);
        chk("trap_step", int'(bus.step), 0);
        chk("trap_exec", int'(bus.exec_phase), 0);
        bus.halt_clear = 1'b1;
        tick();
        bus.halt_clear = 1'b0;
        chk("trap_flag_clr", int'(bus.illegal_op), 0);
        chk("trap_unhalt", int'(bus.halted), 0);
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();
`else
        exp_q.push_back(exp_len(8'hBF));
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        wait_done();
        chk("nop_len", int'(bus.cycle_len), 8);
        tick();
        chk("nop_idle_step", int'(bus.step), 0);
        chk("nop_halted", int'(bus.halted), 0);
`endif

        // randomized back-to-back instructions with random hold
        op = rand_op();
        bus.instruction_reg = op;
        exp_q.push_back(exp_len(op));
        issued = 1;
        fin = 1'b0;
        bus.run = 1'b1;
        for (int c = 0; c < 8000 && !fin; c++) begin
            @(posedge clk);
            #1;
            bus.hold = $urandom_range(3) == 0;
            #1;
            if (bus.instr_done) begin
                if (issued < NRAND) begin
                    op = rand_op();
                    bus.instruction_reg = op;
                    exp_q.push_back(exp_len(op));
                    issued++;
                end else begin
                    bus.run = 1'b0;
                    fin = 1'b1;
                end
            end
        end
        bus.hold = 1'b0;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL rand_timeout: issued %0d want %0d completions", issued, NRAND);
        end
        tick();
        tick();
        chk("rand_idle_step", int'(bus.step), 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Parametrised step sequencer for the relay computer control path. It replaces the fixed per-instruction state ring with a fetch/execute step counter whose execute length is decoded from the opcode class. It adds a hold (stall) input, run/idle control, a halt latch with clear, and an instruction-done strobe. Its step outputs feed the control-signal decode (Ld*/Sel*/Mem*/ALU pins) downstream.

Parameters:
MAX_STEPS, 24, longest instruction in steps; sets step counter range.
FETCH_STEPS, 4, fetch-phase length; the last fetch step loads the instruction register.
STEP_W, $clog2(MAX_STEPS+1), step counter width (derived, not overridden).

Ports:
clock  input  1  system clock; all state changes on the rising edge.
initialize_n  input  1  asynchronous active-low reset.
run  input  1  start/continue execution.
hold  input  1  freezes state, step and strobes (memory wait).
halt_clear  input  1  leaves HALTED for IDLE.
instruction_reg  input  8  current opcode; sampled at the FETCH->EXEC edge.
step  output  STEP_W  current step: 1..cycle_len when active, 0 in IDLE/HALTED.
fetch_phase  output  1  state==FETCH.
exec_phase  output  1  state==EXEC.
ld_inst_strobe  output  1  step==FETCH_STEPS && !hold.
instr_done  output  1  EXEC && step==cycle_len && !hold.
cycle_len  output  STEP_W  latched length of the current instruction.
halted  output  1  state==HALTED.

Behaviour:
- Reset (async, initialize_n=0): state=IDLE, step=0, cycle_len=0, all strobes 0; this takes effect mid-instruction with no completion.
- FSM states: IDLE, FETCH, EXEC, HALTED. All outputs are registered or derived only from registered state.
- IDLE: run=1 -> FETCH with step=1 on the next edge. Otherwise stays.
- hold=1 in any state: nothing changes. Strobes are forced 0, so there is no double load or double done.
- FETCH: step increments each edge.
  - At step==FETCH_STEPS the next edge enters EXEC with step=FETCH_STEPS+1.
  - On that same edge, cycle_len is latched from the decode of instruction_reg.
- Decode lengths (total steps):
  - 00xxxxxx MOV8: 8.
  - 01xxxxxx SETAB: 8.
  - 1000xxxx ALU: 8.
  - 100100rr LOAD, 100110rr STORE: 12.
  - 1010xxxx MOV16/RETURN: 10.
  - 10101110 HALT: 10.
  - 10110000 INC_XY: 14.
  - 11xxxxxx GOTO family: 24.
  - Any other code is illegal.
- EXEC: step increments until step==cycle_len. At that step the next edge goes:
  - to HALTED if the opcode was HALT;
  - else to FETCH with step=1 if run=1;
  - else to IDLE with step=0.
- run deasserted mid-instruction does not abort; the current instruction completes.
- HALTED: holds, step=0. halt_clear=1 -> IDLE. run is ignored while halted. halt_clear outside HALTED is ignored.
- Simultaneous halt_clear and hold: hold wins.
- The step counter never exceeds MAX_STEPS. Any length above MAX_STEPS is clamped to MAX_STEPS. An elaboration assertion requires FETCH_STEPS < 8.

Optional Feature:
SEQ_ILLEGAL_TRAP_EN
- Defined: adds output port illegal_op (1 bit). An illegal opcode latched at FETCH->EXEC sends the FSM to HALTED immediately. illegal_op stays 1 until halt_clear or reset.
- Undefined: no port. An illegal opcode executes as an 8-step NOP with no side effects.

Decomposition:
- Package seq_pkg holds:
  - the state enum (seq_state_t);
  - the opcode class enum (MOV8, SETAB, ALU, LDST, MOV16, HALT, INCXY, GOTO, ILLEGAL);
  - the length constants (LEN_SHORT=8, LEN_MOV16=10, LEN_LDST=12, LEN_INCXY=14, LEN_GOTO=24).
- Sub-module cycle_sequencer_decode: combinational opcode -> {class, length}. It is reused by the control-signal decoder.

Test Plan:
- Reset then run=1 with instruction_reg=8'b10000000:
  - fetch steps 1..4 with ld_inst_strobe at step 4;
  - EXEC steps 5..8;
  - instr_done at step 8, cycle_len=8;
  - next cycle step=1.
- Opcode 8'b11100110 (JUMP) with hold=1 for 3 cycles at step 10: step stays 10 for 3 cycles, then reaches 24; instr_done is asserted exactly once.
- Opcode 8'b10101110 (HALT): after step 10, halted=1 and step=0; run is ignored; halt_clear=1 -> IDLE.
- Opcode 8'b10011000 (STORE A) with run dropped at step 6: completes to step 12, then IDLE.
- initialize_n pulsed low at step 17 of a GOTO: step=0 and state IDLE asynchronously, with no instr_done.
- Opcode 8'b10111111 (illegal):
  - with SEQ_ILLEGAL_TRAP_EN: HALTED and illegal_op=1 at step 5;
  - without: 8-step NOP.
